// File: rtl/ser_pkg.sv
// rtl/ser_pkg.sv - shared state typedef and constants for parity_frame_serializer (PARITY_BIT_EN adds PAR)
package ser_pkg;

  localparam int DEFAULT_DATA_W = 8;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_SHIFT = 2'b01;

`ifdef PARITY_BIT_EN
  localparam logic [1:0] ST_PAR   = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT,
    PAR   = ST_PAR
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT
  } state_t;
`endif

endpackage

// File: rtl/parity_frame_serializer_if.sv
// rtl/parity_frame_serializer_if.sv - load/serial handshake bundle for parity_frame_serializer
interface parity_frame_serializer_if
  import ser_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
);
  logic [DATA_W-1:0] data_in;
  logic              load;
  logic              ready;
  logic              x;
  logic              bit_valid;
  logic              done;

  // Producer side: supplies words, watches the serial stream
  modport master (
    output data_in, load,
    input  ready, x, bit_valid, done
  );

  // Serializer side
  modport slave (
    input  data_in, load,
    output ready, x, bit_valid, done
  );
endinterface

// File: rtl/piso_shift_reg.sv
// rtl/piso_shift_reg.sv - parallel-in serial-out word register, shifts toward the LSB
module piso_shift_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_shift,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_next_bit
);
  logic [DATA_W-1:0] r_word;

  // Capture on load, otherwise drop the bit just sent and pull zeros in from the top
  always_ff @(posedge clk) begin
    if (rst) begin
      r_word <= '0;
    end else if (i_load) begin
      r_word <= i_data;
    end else if (i_shift) begin
      r_word <= r_word >> 1;
    end
  end

  // Bit 0 is already on the line; bit 1 is what goes out next
  assign o_next_bit = r_word[1];
endmodule

// File: rtl/parity_frame_serializer.sv
// rtl/parity_frame_serializer.sv - LSB-first word serializer; PARITY_BIT_EN appends an even-parity bit
module parity_frame_serializer
  import ser_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input logic                      clk,
  input logic                      rst,
  parity_frame_serializer_if.slave bus
);
  localparam int               CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
`ifndef PARITY_BIT_EN
  localparam logic [CNT_W-1:0] CNT_PENULT = CNT_W'(DATA_W - 2);
`endif

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ready;
  logic             r_x;
  logic             r_bit_valid;
  logic             r_done;

  logic w_load;
  logic w_shift;
  logic w_next_bit;

  assign w_load  = (r_state == IDLE) && r_ready && bus.load;
  assign w_shift = (r_state == SHIFT);

  piso_shift_reg #(
    .DATA_W(DATA_W)
  ) u_piso (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_load),
    .i_shift   (w_shift),
    .i_data    (bus.data_in),
    .o_next_bit(w_next_bit)
  );

`ifdef PARITY_BIT_EN
  logic r_parity;

  // Parity is taken from the word at acceptance so later data_in changes cannot leak in
  always_ff @(posedge clk) begin
    if (rst) begin
      r_parity <= 1'b0;
    end else if (w_load) begin
      r_parity <= ^bus.data_in;
    end
  end
`endif

  // Frame sequencer: every output is registered and set one edge ahead of its cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_ready     <= 1'b1;
      r_x         <= 1'b0;
      r_bit_valid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_cnt       <= '0;
          r_x         <= 1'b0;
          r_bit_valid <= 1'b0;
          r_done      <= 1'b0;
          r_ready     <= 1'b1;
          if (w_load) begin
            r_state     <= SHIFT;
            r_ready     <= 1'b0;
            r_x         <= bus.data_in[0];
            r_bit_valid <= 1'b1;
          end
        end
        SHIFT: begin
          if (r_cnt == CNT_LAST) begin
`ifdef PARITY_BIT_EN
            r_state     <= PAR;
            r_x         <= r_parity;
            r_bit_valid <= 1'b1;
            r_done      <= 1'b1;
`else
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_x         <= 1'b0;
            r_bit_valid <= 1'b0;
            r_done      <= 1'b0;
            r_ready     <= 1'b1;
`endif
          end else begin
            r_cnt <= r_cnt + 1'b1;
            r_x   <= w_next_bit;
`ifdef PARITY_BIT_EN
            r_done <= 1'b0;
`else
            r_done <= (r_cnt == CNT_PENULT);
`endif
          end
        end
`ifdef PARITY_BIT_EN
        PAR: begin
          r_state     <= IDLE;
          r_cnt       <= '0;
          r_x         <= 1'b0;
          r_bit_valid <= 1'b0;
          r_done      <= 1'b0;
          r_ready     <= 1'b1;
        end
`endif
        default: begin
          r_state     <= IDLE;
          r_cnt       <= '0;
          r_x         <= 1'b0;
          r_bit_valid <= 1'b0;
          r_done      <= 1'b0;
          r_ready     <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ready     = r_ready;
  assign bus.x         = r_x;
  assign bus.bit_valid = r_bit_valid;
  assign bus.done      = r_done;
endmodule
